// File: rtl/duty_cycle_generator.sv
// -----------------------------------------------------------------------------
// duty_cycle_generator
//
// Generates a periodic signal with a programmable duty cycle. The window is
// fixed at 2^WIDTH clock cycles. A programmed duty of N produces exactly N
// contiguous high cycles per window, so a downstream duty-cycle counter that
// integrates pwm_out over one window reads back N.
//
// New duty values are double-buffered. While the generator is running, a load
// is parked in a pending register. That register moves into the active register
// only on the last cycle of a window. As a result, no window ever mixes two duty
// values.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   level; high starts / continues generation
//   duty_in    in   WIDTH  requested high cycles per window (0 .. 2^WIDTH-1)
//   duty_load  in   one-cycle strobe that captures duty_in
//   duty_ack   out  one-cycle pulse: a loaded duty value has become active
//   pwm_out    out  generated signal (registered, one cycle behind count)
//   carry      out  one-cycle pulse on the last cycle of every window
//   count      out  WIDTH  current position inside the window
//   busy       out  high whenever the state machine is not IDLE
// -----------------------------------------------------------------------------
module duty_cycle_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  output logic             duty_ack,
  output logic             pwm_out,
  output logic             carry,
  output logic [WIDTH-1:0] count,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  // IDLE : counter parked at 0, output low.
  // RUN  : generating, enable high.
  // STOP : enable has dropped. The current window is finished before
  //        returning to IDLE, so the measurement side always sees whole
  //        windows.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_duty_active;
  logic [WIDTH-1:0] r_duty_pending;
  logic             r_pending_valid;
  logic             r_pwm;
  logic             r_ack;

  // ---------------------------------------------------------------------------
  // Combinational next-state values
  // ---------------------------------------------------------------------------
  state_t           w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_duty_active_next;
  logic [WIDTH-1:0] w_duty_pending_next;
  logic             w_pending_valid_next;
  logic             w_ack_next;
  logic             w_running;
  logic             w_at_max;

  assign w_running = (r_state == ST_RUN) || (r_state == ST_STOP);
  assign w_at_max  = (r_count == MAX_COUNT);

  // ---------------------------------------------------------------------------
  // State transitions
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default before the case; a path
    // that leaves one unassigned would infer a latch.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Dropping enable exactly on the last cycle finishes the window
        // right there, so STOP is skipped.
        if (!enable) begin
          w_state_next = w_at_max ? ST_IDLE : ST_STOP;
        end
      end
      ST_STOP: begin
        // Re-enabling resumes RUN without restarting the window.
        if (enable) begin
          w_state_next = ST_RUN;
        end else if (w_at_max) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Free-running window counter while active. It wraps MAX -> 0 naturally,
  // which also gives count = 0 on entry to IDLE. In IDLE it holds at 0.
  assign w_count_next = w_running ? (r_count + WIDTH'(1)) : '0;

  // ---------------------------------------------------------------------------
  // Duty double-buffer
  //
  // Priority on the boundary cycle: a coincident load wins over an older
  // pending value and also clears it, so only one ack is produced.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_duty_active_next   = r_duty_active;
    w_duty_pending_next  = r_duty_pending;
    w_pending_valid_next = r_pending_valid;
    w_ack_next           = 1'b0;

    if (!w_running) begin
      // Not generating: nothing can be disturbed, apply immediately.
      if (duty_load) begin
        w_duty_active_next = duty_in;
        w_ack_next         = 1'b1;
      end
    end else if (w_at_max) begin
      // Last cycle of the window: whatever is applied here governs the
      // window that starts at count = 0, including a window that ends
      // into IDLE.
      if (duty_load) begin
        w_duty_active_next   = duty_in;
        w_pending_valid_next = 1'b0;
        w_ack_next           = 1'b1;
      end else if (r_pending_valid) begin
        w_duty_active_next   = r_duty_pending;
        w_pending_valid_next = 1'b0;
        w_ack_next           = 1'b1;
      end
    end else if (duty_load) begin
      // Mid-window: park the value. A later load overwrites it.
      w_duty_pending_next  = duty_in;
      w_pending_valid_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: all state updates below use non-blocking assignments, so every
  // register samples the pre-edge values of its neighbours, whatever the
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_count         <= '0;
      r_duty_active   <= '0;
      r_duty_pending  <= '0;
      r_pending_valid <= 1'b0;
      r_pwm           <= 1'b0;
      r_ack           <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_count         <= w_count_next;
      r_duty_active   <= w_duty_active_next;
      r_duty_pending  <= w_duty_pending_next;
      r_pending_valid <= w_pending_valid_next;
      r_ack           <= w_ack_next;
      // Compared against the current count, so pwm_out trails count by one
      // cycle. Duty N gives high for count 0 .. N-1 and therefore N cycles.
      r_pwm           <= w_running && (r_count < r_duty_active);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pwm_out  = r_pwm;
  assign duty_ack = r_ack;
  assign count    = r_count;
  assign busy     = (r_state != ST_IDLE);
  assign carry    = w_running && w_at_max;

endmodule

// File: tb/tb_duty_cycle_generator.sv
// -----------------------------------------------------------------------------
// tb_duty_cycle_generator
//
// The stimulus process pushes expected events into a queue as it issues each
// directed vector. There are two kinds of event:
//   EV_ACK : a duty_ack pulse
//   EV_WIN : one complete window, with its number of pwm_out high cycles
// The monitor runs on the falling edge. It pops an entry and compares it each
// time the DUT produces one of these events. It also checks every carry pulse
// against the window position.
// -----------------------------------------------------------------------------
module tb_duty_cycle_generator;

  localparam int WIDTH = 8;
  localparam int MAXC  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [WIDTH-1:0] duty_in;
  logic             duty_load;
  logic             duty_ack;
  logic             pwm_out;
  logic             carry;
  logic [WIDTH-1:0] count;
  logic             busy;

  duty_cycle_generator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .duty_in   (duty_in),
    .duty_load (duty_load),
    .duty_ack  (duty_ack),
    .pwm_out   (pwm_out),
    .carry     (carry),
    .count     (count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {EV_ACK, EV_WIN} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push(input ev_kind_e k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input ev_kind_e k, input int v);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_%s: got %s %0d, expected no event (t=%0t)",
               k.name(), k.name(), v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_err++;
        $display("FAIL sb_%s: got %s %0d, expected %s %0d (t=%0t)",
                 k.name(), k.name(), v, e.kind.name(), e.val, $time);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at posedge+1 with count == v. Anything driven now is seen by
  // the DUT on the edge where count == v.
  task automatic wait_count(input int v);
    int n;
    n = 0;
    while (count !== WIDTH'(v) && n < 1000) begin
      tick(1);
      n++;
    end
    if (n >= 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_count: count stuck at %0d, expected %0d within 1000 cycles", count, v);
    end
  endtask

  task automatic load(input int d);
    duty_in   = WIDTH'(d);
    duty_load = 1'b1;
    tick(1);
    duty_load = 1'b0;
  endtask

  // Starts from IDLE and runs n whole windows. enable is dropped on the last
  // cycle so that the DUT returns straight to IDLE.
  task automatic run_windows(input int n, input int exp_high);
    for (int i = 0; i < n; i++) push(EV_WIN, exp_high);
    enable = 1'b1;
    tick(1);
    for (int i = 0; i < n - 1; i++) begin
      wait_count(MAXC);
      tick(1);
    end
    wait_count(MAXC);
    enable = 1'b0;
    tick(1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: falling-edge sampling, away from the active edge
  // ---------------------------------------------------------------------------
  int   mon_acc;
  logic mon_carry_d;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_acc     = 0;
      mon_carry_d = 1'b0;
    end else if (!clk) begin
      // pwm_out now reflects the previous cycle's count. The sample taken
      // one cycle after carry is therefore the last one of that window.
      mon_acc += int'(pwm_out);
      if (mon_carry_d) begin
        sb_compare(EV_WIN, mon_acc);
        mon_acc = 0;
      end
      if (duty_ack) sb_compare(EV_ACK, 0);
      if (carry) begin
        check("carry_pos", int'(count), MAXC);
        check("carry_busy", int'(busy), 1);
      end
      mon_carry_d = carry;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    duty_in   = '0;
    duty_load = 1'b0;
    tick(2);
    check("rst_pwm",   int'(pwm_out),  0);
    check("rst_ack",   int'(duty_ack), 0);
    check("rst_carry", int'(carry),    0);
    check("rst_count", int'(count),    0);
    check("rst_busy",  int'(busy),     0);
    rst_n = 1'b1;
    tick(2);

    // Duty 64 over three windows, one ack.
    push(EV_ACK, 0);
    load(64);
    check("idle_busy", int'(busy), 0);
    run_windows(3, 64);
    check("end_busy",  int'(busy),  0);
    check("end_count", int'(count), 0);
    tick(1);
    check("end_pwm",   int'(pwm_out), 0);
    check("idle_carry", int'(carry),  0);

    // Extreme duties.
    push(EV_ACK, 0);
    load(0);
    run_windows(2, 0);
    push(EV_ACK, 0);
    load(255);
    run_windows(2, 255);

    // Double-buffered update: 30 then 200 mid-window. The current window
    // keeps 100, the next window gets 200, and a single ack is produced at
    // the boundary.
    push(EV_ACK, 0);
    load(100);
    push(EV_WIN, 100);
    push(EV_ACK, 0);
    push(EV_WIN, 200);
    enable = 1'b1;
    tick(1);
    wait_count(10);
    load(30);
    wait_count(50);
    load(200);
    wait_count(MAXC);
    check("no_early_ack", int'(duty_ack), 0);
    tick(1);
    check("ack_after_boundary", int'(duty_ack), 1);
    wait_count(MAXC);
    enable = 1'b0;
    tick(1);

    // A load on the boundary overrides a parked value of 77. Both following
    // windows run at 10, and there is no second ack.
    push(EV_WIN, 200);
    push(EV_ACK, 0);
    push(EV_WIN, 10);
    push(EV_WIN, 10);
    enable = 1'b1;
    tick(1);
    wait_count(20);
    load(77);
    wait_count(MAXC);
    load(10);
    wait_count(MAXC);
    tick(1);
    wait_count(MAXC);
    enable = 1'b0;
    tick(1);

    // enable dropped at count 40: the window finishes in STOP.
    push(EV_WIN, 10);
    enable = 1'b1;
    tick(1);
    wait_count(40);
    enable = 1'b0;
    tick(1);
    check("stop_busy", int'(busy), 1);
    wait_count(MAXC);
    check("stop_carry", int'(carry), 1);
    tick(1);
    check("stop_idle_busy",  int'(busy),  0);
    check("stop_idle_count", int'(count), 0);
    tick(1);
    check("stop_idle_pwm", int'(pwm_out), 0);

    // enable dropped at 40 and re-asserted at 100: counting continues
    // without a gap.
    push(EV_WIN, 10);
    push(EV_WIN, 10);
    enable = 1'b1;
    tick(1);
    wait_count(40);
    enable = 1'b0;
    tick(1);
    wait_count(100);
    enable = 1'b1;
    tick(1);
    check("resume_busy",  int'(busy),  1);
    check("resume_count", int'(count), 101);
    wait_count(MAXC);
    tick(1);
    check("resume_wrap_busy",  int'(busy),  1);
    check("resume_wrap_count", int'(count), 0);
    wait_count(MAXC);
    enable = 1'b0;
    tick(1);

    // Reset mid-window with a pending load. The pending load is discarded,
    // duty returns to 0, and no ack appears.
    enable = 1'b1;
    tick(1);
    wait_count(60);
    load(150);
    wait_count(120);
    rst_n = 1'b0;
    #1;
    check("mrst_pwm",   int'(pwm_out),  0);
    check("mrst_ack",   int'(duty_ack), 0);
    check("mrst_carry", int'(carry),    0);
    check("mrst_count", int'(count),    0);
    check("mrst_busy",  int'(busy),     0);
    tick(1);
    rst_n = 1'b1;
    push(EV_WIN, 0);
    push(EV_WIN, 0);
    tick(1);
    wait_count(MAXC);
    tick(1);
    wait_count(MAXC);
    enable = 1'b0;
    tick(4);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/duty_cycle_generator.md
Name: duty_cycle_generator

Overview:
- Produces a periodic digital signal with a programmed duty cycle over a fixed window of 2^WIDTH clock cycles.
- It is the stimulus side of the duty-cycle measurement path. Its pwm_out feeds the ring/measurement input, so a programmed duty N must read back as a count of N per window.
- Duty updates are double-buffered and applied only at window boundaries, so no window ever contains a mixed duty.

Parameters:
WIDTH, 8, counter/duty width; window length = 2^WIDTH cycles (256 by default)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; high starts/continues generation
duty_in  input  WIDTH  requested number of high cycles per window (0..2^WIDTH-1)
duty_load  input  1  one-cycle strobe; captures duty_in
duty_ack  output  1  one-cycle pulse: a loaded duty value is now active
pwm_out  output  1  generated signal, registered
carry  output  1  one-cycle pulse on the last cycle of each window
count  output  WIDTH  current window position
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count, duty_active, duty_pending=0; pending_valid=0.
  - pwm_out=0, duty_ack=0, carry=0, busy=0.
- State machine IDLE / RUN / STOP:
  - IDLE -> RUN when enable=1. Count is 0 in the first RUN cycle.
  - RUN -> STOP when enable=0 and count != MAX (MAX = 2^WIDTH-1).
  - RUN -> IDLE when enable=0 and count == MAX.
  - STOP -> RUN when enable=1 (no window restart; counting is uninterrupted).
  - STOP -> IDLE when count == MAX. Count returns to 0.
- Counter: in RUN/STOP, count increments by 1 every cycle and wraps MAX -> 0. In IDLE, count holds at 0.
- pwm_out:
  - Flop: pwm_out <= (state is RUN or STOP) && (count < duty_active).
  - pwm_out therefore lags count by exactly 1 cycle.
  - duty N gives exactly N high cycles per window, contiguous, starting 1 cycle after count=0.
  - N=0: constantly low.
  - N=MAX: high for MAX cycles, low for 1 cycle.
  - pwm_out returns to 0 one cycle after entering IDLE.
- carry:
  - Combinational decode of registered state: (state is RUN or STOP) && count == MAX.
  - Exactly one pulse per 2^WIDTH cycles while running. Never asserted in IDLE.
- Duty loading:
  - duty_load in IDLE: duty_active <= duty_in; duty_ack=1 the next cycle.
  - duty_load in RUN/STOP at count != MAX: duty_pending <= duty_in, pending_valid <= 1.
  - A further load before the boundary overwrites duty_pending (last write wins). Only one ack is issued.
  - Window boundary (count == MAX, RUN/STOP) with pending_valid: duty_active <= duty_pending, pending_valid <= 0, duty_ack=1 the next cycle. The new duty governs the window that starts at count=0.
  - duty_load coincident with count == MAX: duty_in goes directly to duty_active (it overrides any pending value), pending_valid cleared, single ack next cycle.
  - Window ending into IDLE with pending_valid: the pending value still transfers to duty_active, with ack.
- duty_ack is never high for two consecutive cycles unless two separate loads each complete.
- enable has no effect on duty loading.
- Reset mid-window: all outputs go to reset values immediately (async). A pending duty is discarded; no ack.

Test Plan:
- Load duty_in=64 in IDLE, then enable=1 for 3 windows.
  - duty_ack pulses once.
  - pwm_out is high for exactly 64 cycles per window.
  - carry pulses every 256 cycles at count=255.
- duty 0, then duty 255, each over 2 windows.
  - duty 0: pwm_out never high.
  - duty 255: exactly 255 high cycles and 1 low cycle per window.
- Running at duty 100; load 30 at count=10, then 200 at count=50.
  - No ack until count=255; a single duty_ack follows.
  - Next window has exactly 200 high cycles; the current window keeps 100.
- duty_load of 10 exactly at count=255.
  - Next window has 10 high cycles.
  - One duty_ack.
  - No stale pending value applied later.
- enable dropped at count=40.
  - Counting continues to 255; carry pulses.
  - busy falls after the wrap; count=0 and pwm_out=0 in IDLE.
  - Re-asserting enable at count=100 instead keeps RUN with no gap.
- rst_n pulsed low at count=120 with a pending load.
  - All outputs read 0 immediately.
  - After release with enable=1, windows run at duty 0 and no duty_ack appears.
